// File: rtl/register_file_pkg.sv
// Shared defaults and word/address types for the register file.
package register_file_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int ADDR_W_DEF = 3;

    typedef logic [DATA_W_DEF-1:0] data_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/regfile_read_mux.sv
// One asynchronous read port: selects a register by address.
// Addresses with no register behind them read as zero.
module regfile_read_mux #(
    parameter int DATA_W   = 12,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Compare against each implemented index so unimplemented addresses fall through to zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = regs[i];
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// Register file: NUM_REGS x DATA_W storage, one synchronous write port and
// two independent asynchronous read ports. Register 0 is an ordinary
// register. There is no write-to-read bypass: a read of the address being
// written shows the old value until the clock edge commits the write.
// we is a plain per-cycle strobe with no backpressure; a write happens on
// every rising edge where we=1 and reset=0.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] read1Addr,
    input  logic [ADDR_W-1:0] read2Addr,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Next-state: hold everything, replace only the addressed register on a write.
    // Writes to addresses without a register match no index and are dropped.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (we && (writeAddr == ADDR_W'(i))) begin
                regs_d[i] = writeData;
            end
        end
    end

    // Storage update; reset wins over a write on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_read_mux #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) u_read_mux_1 (
        .regs   (regs_q),
        .rd_addr(read1Addr),
        .rd_data(readData1)
    );

    regfile_read_mux #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) u_read_mux_2 (
        .regs   (regs_q),
        .rd_addr(read2Addr),
        .rd_data(readData2)
    );

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios followed by random traffic,
// checked against an array model through an expected-value queue.
module tb_register_file;
    import register_file_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int AW = ADDR_W_DEF;
    localparam int NR = 2**AW;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          we;
    addr_t         read1Addr;
    addr_t         read2Addr;
    addr_t         writeAddr;
    data_t         writeData;
    data_t         readData1;
    data_t         readData2;

    always #5 clk = ~clk;

    register_file dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .read1Addr(read1Addr),
        .read2Addr(read2Addr),
        .writeAddr(writeAddr),
        .writeData(writeData),
        .readData1(readData1),
        .readData2(readData2)
    );

    // ---------------- reference model ----------------
    // Plain array of register contents, updated once per clock edge.
    data_t model_mem [NR];

    // ---------------- scoreboard ----------------
    logic [2*DW-1:0] exp_q[$];
    string           name_q[$];
    int              total = 0;
    int              bad   = 0;

    // Monitor: each cycle that has an expectation pending, compare both read ports
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [2*DW-1:0] e;
            string           tag;
            e   = exp_q.pop_front();
            tag = name_q.pop_front();
            total++;
            if ({readData1, readData2} !== e) begin
                bad++;
                $display("FAIL %s: got rd1=%h rd2=%h, expected rd1=%h rd2=%h",
                         tag, readData1, readData2, e[2*DW-1:DW], e[DW-1:0]);
            end
        end
    end

    // ---------------- driver ----------------
    // Drive one cycle: apply inputs, optionally expect the pre-edge read
    // values, then let the edge happen and advance the model.
    task automatic step(input logic rst, input logic wen, input addr_t wa,
                        input data_t wd, input addr_t ra1, input addr_t ra2,
                        input logic chk, input string tag);
        reset     = rst;
        we        = wen;
        writeAddr = wa;
        writeData = wd;
        read1Addr = ra1;
        read2Addr = ra2;
        if (chk) begin
            exp_q.push_back({model_mem[ra1], model_mem[ra2]});
            name_q.push_back(tag);
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NR; i++) model_mem[i] = '0;
        end else if (wen) begin
            model_mem[wa] = wd;
        end
        #1;
    endtask

    // Read-only cycle with no write and no reset
    task automatic rd(input addr_t ra1, input addr_t ra2, input string tag);
        step(1'b0, 1'b0, 3'd0, 12'h000, ra1, ra2, 1'b1, tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < NR; i++) model_mem[i] = '0;
        #1;
        step(1'b1, 1'b0, 3'd0, 12'h000, 3'd0, 3'd1, 1'b0, "rst");
        step(1'b1, 1'b0, 3'd0, 12'h000, 3'd0, 3'd1, 1'b0, "rst");

        // reset state: every address reads 0
        rd(3'd0, 3'd1, "reset_0_1");
        for (int a = 0; a < NR; a += 2) rd(addr_t'(a), addr_t'(a + 1), "reset_all");

        // write 2 <- 2, register 1 untouched
        step(1'b0, 1'b1, 3'd2, 12'h002, 3'd2, 3'd1, 1'b1, "wr2_before");
        rd(3'd2, 3'd1, "wr2_after");

        // read-during-write to 0: old value before the edge, new value after
        step(1'b0, 1'b1, 3'd0, 12'hABC, 3'd0, 3'd0, 1'b1, "rdw0_before");
        rd(3'd0, 3'd0, "rdw0_after");

        // we=0 leaves address 3 alone
        step(1'b0, 1'b0, 3'd3, 12'hFFF, 3'd3, 3'd3, 1'b1, "nowe_before");
        rd(3'd3, 3'd2, "nowe_after");

        // same-address reads on both ports, then independent ports
        step(1'b0, 1'b1, 3'd7, 12'h123, 3'd7, 3'd7, 1'b1, "wr7");
        step(1'b0, 1'b1, 3'd1, 12'h456, 3'd7, 3'd7, 1'b1, "wr1");
        rd(3'd7, 3'd7, "same_addr");
        rd(3'd7, 3'd1, "indep_ports");

        // reset beats a write on the same edge, wiping earlier data
        step(1'b1, 1'b1, 3'd5, 12'h555, 3'd5, 3'd7, 1'b1, "rst_wr_before");
        rd(3'd5, 3'd7, "rst_wr_5_7");
        rd(3'd0, 3'd1, "rst_wr_0_1");
        rd(3'd2, 3'd3, "rst_wr_2_3");

        // full-range data at the extremes
        step(1'b0, 1'b1, 3'd6, 12'hFFF, 3'd6, 3'd4, 1'b1, "max_before");
        rd(3'd6, 3'd4, "max_after");

        // random traffic with occasional mid-sequence reset
        for (int n = 0; n < 400; n++) begin
            logic  r;
            logic  w;
            r = ($urandom_range(0, 39) == 0);
            w = ($urandom_range(0, 3) != 0);
            step(r, w, addr_t'($urandom_range(0, NR - 1)), data_t'($urandom),
                 addr_t'($urandom_range(0, NR - 1)), addr_t'($urandom_range(0, NR - 1)),
                 1'b1, "random");
        end

        // drain: every expectation must be consumed within a short bound
        begin
            int waited;
            waited = 0;
            while (exp_q.size() > 0 && waited < 10) begin
                @(posedge clk);
                waited++;
            end
            if (exp_q.size() > 0) begin
                bad++;
                $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
